// File: rtl/wb_accel_sched.sv
// wb_accel_sched: Wishbone transaction scheduler for the shared accelerator
// resources. It accepts one Wishbone transaction at a time and decodes it to
// one target: external-memory BRAM, the FIR AXI-Lite config port, or one of
// three AXI-Stream channels (0 FIR, 1 MM, 2 QS). It then runs that target's
// handshake and returns a single registered ack with its data.
//
// Ports:
//   wb_clk_i, wb_rst_i          clock, synchronous active-high reset
//   wbs_*                       Wishbone classic slave (cyc/stb/we/sel/adr/dat, ack/dat_o)
//   mem_*                       BRAM enable, byte write enables, address, write/read data
//   axl_*                       AXI-Lite aw/w/ar/r handshakes, shared 12-bit address
//   ss_*                        stream-in to accelerators (3 channels, shared tdata)
//   sm_*                        stream-out from accelerators (3 channels, 96-bit tdata)
//   busy_o                      transaction in progress
//   timeout_o                   one-cycle pulse with an ack caused by a timeout
module wb_accel_sched #(
  parameter int MEM_DELAY = 10,
  parameter int SM_DELAY  = 10,
  parameter int TIMEOUT   = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        mem_en_o,
  output logic [3:0]  mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  output logic        axl_awvalid_o,
  output logic        axl_wvalid_o,
  input  logic        axl_awready_i,
  input  logic        axl_wready_i,
  output logic        axl_arvalid_o,
  input  logic        axl_arready_i,
  input  logic        axl_rvalid_i,
  output logic        axl_rready_o,
  output logic [11:0] axl_addr_o,
  output logic [31:0] axl_wdata_o,
  input  logic [31:0] axl_rdata_i,
  output logic [2:0]  ss_tvalid_o,
  input  logic [2:0]  ss_tready_i,
  output logic [31:0] ss_tdata_o,
  input  logic [2:0]  sm_tvalid_i,
  input  logic [95:0] sm_tdata_i,
  output logic [2:0]  sm_tready_o,
  output logic        busy_o,
  output logic        timeout_o
);

  localparam logic [15:0] C_MEM = 16'(MEM_DELAY);
  localparam logic [15:0] C_SM  = 16'(SM_DELAY);
  localparam logic [15:0] C_TO  = 16'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_MEM, S_AXL_W, S_AXL_AR, S_AXL_R, S_SS, S_SM, S_ACK
  } state_t;

  state_t      r_state, w_next, w_dec_state;
  logic [15:0] r_cnt;
  logic [23:0] r_adr;
  logic [31:0] r_wdat, r_dat;
  logic        r_we, r_aw_done, r_w_done, r_to;
  logic [3:0]  r_sel;
  logic [1:0]  r_ch, w_dec_ch;
  logic [2:0]  w_ch_oh;
  logic [31:0] w_sm_data, w_cap_dat;
  logic        w_tmo, w_cap, w_to_set;
  logic        w_aw_hs, w_w_hs, w_ar_hs, w_r_hs, w_ss_hs, w_sm_hs;

  // Address decode, only consumed while IDLE. Unmatched addresses go straight to ACK.
  always_comb begin
    w_dec_state = S_ACK;
    w_dec_ch    = 2'd0;
    if (wbs_adr_i[31:20] == 12'h380) begin
      w_dec_state = S_MEM;
    end else if (wbs_adr_i[31:20] == 12'h300) begin
      case (wbs_adr_i[11:8])
        4'h0: begin
          if (!wbs_adr_i[7]) w_dec_state = wbs_we_i ? S_AXL_W : S_AXL_AR;
          else               w_dec_state = wbs_we_i ? S_SS : S_SM;
        end
        4'h1: begin
          w_dec_state = wbs_we_i ? S_SS : S_SM;
          w_dec_ch    = 2'd1;
        end
        4'h2: begin
          w_dec_state = wbs_we_i ? S_SS : S_SM;
          w_dec_ch    = 2'd2;
        end
        default: w_dec_state = S_ACK;
      endcase
    end
  end

  always_comb begin
    case (r_ch)
      2'd0:    begin w_ch_oh = 3'b001; w_sm_data = sm_tdata_i[31:0];  end
      2'd1:    begin w_ch_oh = 3'b010; w_sm_data = sm_tdata_i[63:32]; end
      default: begin w_ch_oh = 3'b100; w_sm_data = sm_tdata_i[95:64]; end
    endcase
  end

  // The timeout cycle already has every handshake output low, so no handshake
  // can complete in the same cycle a timeout is taken.
  assign w_tmo = (r_cnt == C_TO);

  // Target-side outputs, decoded from state and counter only.
  always_comb begin
    mem_en_o      = 1'b0;
    mem_we_o      = 4'h0;
    axl_awvalid_o = 1'b0;
    axl_wvalid_o  = 1'b0;
    axl_arvalid_o = 1'b0;
    axl_rready_o  = 1'b0;
    ss_tvalid_o   = 3'b000;
    sm_tready_o   = 3'b000;
    case (r_state)
      S_MEM: begin
        mem_en_o = 1'b1;
        mem_we_o = r_sel & {4{r_we}};
      end
      S_AXL_W: begin
        axl_awvalid_o = !w_tmo && !r_aw_done;
        axl_wvalid_o  = !w_tmo && !r_w_done;
      end
      S_AXL_AR: axl_arvalid_o = !w_tmo;
      S_AXL_R:  axl_rready_o  = !w_tmo;
      S_SS:     if (!w_tmo) ss_tvalid_o = w_ch_oh;
      S_SM:     if (!w_tmo && (r_cnt >= C_SM)) sm_tready_o = w_ch_oh;
      default: ;
    endcase
  end

  assign w_aw_hs = axl_awvalid_o & axl_awready_i;
  assign w_w_hs  = axl_wvalid_o & axl_wready_i;
  assign w_ar_hs = axl_arvalid_o & axl_arready_i;
  assign w_r_hs  = axl_rready_o & axl_rvalid_i;
  assign w_ss_hs = |(ss_tvalid_o & ss_tready_i);
  assign w_sm_hs = |(sm_tready_o & sm_tvalid_i);

  // Next state plus the single ack-data capture point. Priority in wait
  // states: abort (cyc low), then timeout, then handshake completion.
  always_comb begin
    w_next    = r_state;
    w_cap     = 1'b0;
    w_cap_dat = 32'h0;
    w_to_set  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          w_next = w_dec_state;
          w_cap  = (w_dec_state == S_ACK);
        end
      end
      S_MEM: begin
        if (!wbs_cyc_i) w_next = S_IDLE;
        else if (r_cnt == C_MEM) begin
          w_next    = S_ACK;
          w_cap     = !r_we;
          w_cap_dat = mem_rdata_i;
        end
      end
      S_AXL_W, S_AXL_AR, S_AXL_R, S_SS, S_SM: begin
        if (!wbs_cyc_i) begin
          w_next = S_IDLE;
        end else if (w_tmo) begin
          w_next    = S_ACK;
          w_cap     = 1'b1;
          w_cap_dat = 32'hDEAD_BEEF;
          w_to_set  = 1'b1;
        end else begin
          case (r_state)
            S_AXL_W: if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
              w_next = S_ACK;
              w_cap  = 1'b1;
            end
            S_AXL_AR: if (w_ar_hs) w_next = S_AXL_R;
            S_AXL_R: if (w_r_hs) begin
              w_next    = S_ACK;
              w_cap     = 1'b1;
              w_cap_dat = axl_rdata_i;
            end
            S_SS: if (w_ss_hs) w_next = S_ACK;
            default: if (w_sm_hs) begin
              w_next    = S_ACK;
              w_cap     = 1'b1;
              w_cap_dat = w_sm_data;
            end
          endcase
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state   <= S_IDLE;
      r_cnt     <= 16'h0;
      r_adr     <= 24'h0;
      r_wdat    <= 32'h0;
      r_dat     <= 32'h0;
      r_we      <= 1'b0;
      r_sel     <= 4'h0;
      r_ch      <= 2'd0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_to      <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_cap) r_dat <= w_cap_dat;
      if (r_state == S_IDLE) begin
        // Counter and per-transaction flags start fresh for every wait state entry.
        r_cnt     <= 16'h0;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
        r_to      <= 1'b0;
        if (wbs_cyc_i && wbs_stb_i) begin
          r_adr  <= wbs_adr_i[23:0];
          r_wdat <= wbs_dat_i;
          r_we   <= wbs_we_i;
          r_sel  <= wbs_sel_i;
          r_ch   <= w_dec_ch;
        end
      end else begin
        r_cnt <= r_cnt + 16'd1;
        if (w_aw_hs)  r_aw_done <= 1'b1;
        if (w_w_hs)   r_w_done  <= 1'b1;
        if (w_to_set) r_to      <= 1'b1;
      end
    end
  end

  assign wbs_ack_o   = (r_state == S_ACK);
  assign timeout_o   = (r_state == S_ACK) && r_to;
  assign busy_o      = (r_state != S_IDLE);
  assign wbs_dat_o   = r_dat;
  assign mem_addr_o  = {8'h0, r_adr};
  assign mem_wdata_o = r_wdat;
  assign axl_addr_o  = r_adr[11:0];
  assign axl_wdata_o = r_wdat;
  assign ss_tdata_o  = r_wdat;

endmodule

// File: doc/wb_accel_sched.md
# wb_accel_sched

Wishbone transaction scheduler for the user project. It sits between the Wishbone slave port and the shared accelerator resources: the external-memory BRAM, the FIR AXI-Lite config port, and three AXI-Stream channels (FIR, MM, QS). It accepts one Wishbone transaction at a time, decodes it, and sequences the matching handshake on exactly one target. It returns a single registered ack/data, replacing per-target ack ORing and shared delay counters.

## Interface
Parameters:
- MEM_DELAY, 10, BRAM wait cycles before read data capture/ack
- SM_DELAY, 10, cycles before sm_tready_o may assert on a stream read
- TIMEOUT, 255, wait-state cycle limit; must exceed MEM_DELAY and SM_DELAY

Ports:
- wb_clk_i  in  1  single clock, all logic on rising edge
- wb_rst_i  in  1  synchronous, active-high reset
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic controls
- wbs_sel_i  in  4  byte selects
- wbs_adr_i  in  32  address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  one-cycle ack
- wbs_dat_o  out  32  registered read data
- mem_en_o  out  1  BRAM enable
- mem_we_o  out  4  BRAM byte write enables
- mem_addr_o  out  32  {8'h0, latched adr[23:0]}
- mem_wdata_o  out  32  latched write data
- mem_rdata_i  in  32  BRAM read data, 1-cycle latency
- axl_awvalid_o, axl_wvalid_o  out  1  AXI-Lite write address/data valid
- axl_awready_i, axl_wready_i  in  1  AXI-Lite write readies
- axl_arvalid_o  out  1  read address valid
- axl_arready_i  in  1  read address ready
- axl_rvalid_i  in  1  read data valid
- axl_rready_o  out  1  read data ready
- axl_addr_o  out  12  latched adr[11:0], shared for aw/ar
- axl_wdata_o  out  32  latched write data
- axl_rdata_i  in  32  read data
- ss_tvalid_o  out  3  stream-in valid, bit 0 FIR, 1 MM, 2 QS
- ss_tready_i  in  3  stream-in ready
- ss_tdata_o  out  32  latched write data, shared
- sm_tvalid_i  in  3  stream-out valid
- sm_tdata_i  in  96  stream-out data, channel n at [32n+31:32n]
- sm_tready_o  out  3  stream-out ready
- busy_o  out  1  state != IDLE
- timeout_o  out  1  one-cycle pulse concurrent with a timeout ack

## Operation
- Decode is evaluated in IDLE only. On cyc&stb, latch adr, dat, we, and sel:
  - adr[31:20]==12'h380 → MEM
  - adr[31:20]==12'h300, adr[11:8]==0, adr[7]==0 → AXL
  - adr[31:20]==12'h300, adr[11:8]==0, adr[7]==1 → stream ch0
  - adr[31:20]==12'h300, adr[11:8]==1 → ch1
  - adr[31:20]==12'h300, adr[11:8]==2 → ch2
  - anything else → UNMAPPED
- States: IDLE, MEM, AXL_W, AXL_AR, AXL_R, SS, SM, ACK. A 16-bit cycle counter clears on leaving IDLE and increments every wait-state cycle.
- MEM: mem_en_o=1, mem_we_o=sel&{4{we}}. When cnt==MEM_DELAY, capture mem_rdata_i (reads) and go to ACK. MEM never times out.
- AXL_W (we=1): assert awvalid and wvalid. Drop each independently after its own handshake. Go to ACK when both are done, in either order or the same cycle. Ack data is 0.
- AXL_AR (we=0): arvalid until arready, then AXL_R. In AXL_R, rready=1 until rvalid; capture axl_rdata_i, then ACK.
- SS (stream write): ss_tvalid_o[ch]=1 until ss_tready_i[ch], then ACK.
- SM (stream read): sm_tready_o[ch]=1 once cnt>=SM_DELAY. On tvalid&tready, capture channel data, then ACK.
- UNMAPPED: IDLE→ACK directly, data 0.
- ACK: wbs_ack_o=1 for exactly one cycle, then IDLE. wbs_dat_o holds the last captured value until the next capture.
- Timeout: in AXL_*, SS, or SM, when cnt==TIMEOUT:
  - drop all handshake outputs
  - capture 32'hDEAD_BEEF
  - ACK with timeout_o=1
- Abort: wbs_cyc_i low in any wait state → IDLE next edge, all handshake outputs low, no ack.
- Only one target's valid/ready outputs are ever high in a given cycle.

## Timing
- Reset, including mid-transaction: state IDLE, counter 0. Every output is 0, including wbs_dat_o, mem_*, axl_*, ss_*, sm_*, busy_o, and timeout_o. Any in-flight handshake is dropped.
- Cycle 0 is the first cycle cyc&stb is high. Ack cycles with targets ready:
  - UNMAPPED: 1
  - SS: 2
  - AXL write: 2
  - AXL read: 3
  - MEM: MEM_DELAY+2, i.e. 12 by default
  - SM: SM_DELAY+2
- Each target stall cycle adds one cycle.
- The cycle after ack is IDLE. The earliest next request is sampled one cycle after ack, so a master still holding stb in the ack cycle is not re-accepted.
- All outputs are registered or decoded from state only. There is no combinational path from any *_ready/valid input to wbs_ack_o.

## Test plan
- MEM write 0x12345678, sel=4'hF, to 0x3800_0010, then read it back → each ack at cycle 12; mem_we_o=4'hF only during the write; read returns 0x12345678.
- AXL write to 0x3000_0010 with wready one cycle after awready → ack at cycle 3. AXL read with arready@1, rvalid@4 → ack cycle 5, data = axl_rdata_i.
- Stream ch1 write at 0x3000_0100 with ss_tready_i[1] low for 5 cycles → ss_tvalid_o[1] high cycles 1–6, ack cycle 7, ss_tvalid_o[0]/[2] never high.
- Stream ch2 read at 0x3000_0280 with sm_tvalid_i[2] high, data 0xCAFE0002 → sm_tready_o[2] rises cycle 11, ack cycle 12 with 0xCAFE0002.
- ch0 read with sm_tvalid_i low forever → ack with 0xDEADBEEF and timeout_o pulse at cnt==255. Separately, address 0x3100_0000 → ack cycle 1, data 0.
- Assert wb_rst_i during MEM cnt=5, and separately drop cyc mid-AXL_AR → all outputs 0 next cycle, no ack, next request serviced normally.
